// File: rtl/ex_mem_pkg.sv
// Shared EX/MEM definitions: FSM encoding, default widths and the execute-to-memory bundle.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ex_mem_pkg;

    localparam int DW_DEF = 16;
    localparam int RW_DEF = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } ex_mem_state_t;

    // Layout shared with the upstream execute stage at the default widths.
    typedef struct packed {
        logic [DW_DEF-1:0] result;
        logic [DW_DEF-1:0] st_data;
        logic              wr_en;
        logic [RW_DEF-1:0] wr_reg;
        logic              mem_rd;
        logic              mem_wr;
        logic              halt;
    } ex_mem_bus_t;

endpackage

// File: rtl/ex_mem_fwd.sv
// EX-to-EX forwarding qualification; also instantiated by the hazard unit.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows whatever the held entry presents.
module ex_mem_fwd
    import ex_mem_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          ent_valid,
    input  logic          ent_wr_en,
    input  logic          ent_mem_rd,
    input  logic [RW-1:0] ent_wr_reg,
    input  logic [DW-1:0] ent_result,
    output logic          fwd_valid,
    output logic [RW-1:0] fwd_reg,
    output logic [DW-1:0] fwd_data
);

    // Load data does not exist yet at this point, so loads are never candidates.
    assign fwd_valid = ent_valid & ent_wr_en & ~ent_mem_rd;
    assign fwd_reg   = ent_wr_reg;
    assign fwd_data  = ent_result;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, forwarding and HALT drain FSM.
// Latency: 1 cycle from accepted EX instruction to mem_* outputs; full throughput.
// Backpressure: mem_ready low holds the entry bit-exact and drops ex_ready.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [DW-1:0] ex_result,
    input  logic          ex_wr_en,
    input  logic [RW-1:0] ex_wr_reg,
    input  logic          ex_mem_rd,
    input  logic          ex_mem_wr,
    input  logic [DW-1:0] ex_st_data,
    input  logic          ex_halt,
    input  logic          ex_flush,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [DW-1:0] mem_result,
    output logic [DW-1:0] mem_st_data,
    output logic          mem_wr_en,
    output logic          mem_mem_rd,
    output logic          mem_mem_wr,
    output logic [RW-1:0] mem_wr_reg,
    output logic          fwd_valid,
    output logic [RW-1:0] fwd_reg,
    output logic [DW-1:0] fwd_data,
    output logic          halted
);

    ex_mem_state_t state_q, state_d;

    logic          vld_q;
    logic [DW-1:0] result_q;
    logic [DW-1:0] st_data_q;
    logic          wr_en_q;
    logic [RW-1:0] wr_reg_q;
    logic          mem_rd_q;
    logic          mem_wr_q;
    logic          halt_q;

    logic          in_run;
    logic          xfer;
    logic          drain;

    // ex_ready depends only on local state and mem_ready, never on ex_valid.
    assign ex_ready = in_run & (~vld_q | mem_ready);
    assign xfer     = ex_valid & ex_ready & ~ex_flush;
    assign drain    = vld_q & mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= 1'b0;
            result_q  <= '0;
            st_data_q <= '0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            halt_q    <= 1'b0;
        end else if (xfer) begin
            vld_q     <= 1'b1;
            result_q  <= ex_result;
            st_data_q <= ex_st_data;
            wr_en_q   <= ex_wr_en;
            wr_reg_q  <= ex_wr_reg;
            mem_rd_q  <= ex_mem_rd;
            mem_wr_q  <= ex_mem_wr;
            halt_q    <= ex_halt;
        end else if (drain) begin
            vld_q     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (xfer && ex_halt)  state_d = ST_DRAIN;
            ST_DRAIN:  if (drain && halt_q)  state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        in_run = 1'b0;
        halted = 1'b0;
        case (state_q)
            ST_RUN:    in_run = 1'b1;
            ST_HALTED: halted = 1'b1;
            default:   ;
        endcase
    end

    // Controls are masked when empty so downstream never acts on a stale entry.
    assign mem_valid   = vld_q;
    assign mem_result  = result_q;
    assign mem_st_data = st_data_q;
    assign mem_wr_reg  = wr_reg_q;
    assign mem_wr_en   = vld_q & wr_en_q;
    assign mem_mem_rd  = vld_q & mem_rd_q;
    assign mem_mem_wr  = vld_q & mem_wr_q;

    ex_mem_fwd #(.DW(DW), .RW(RW)) u_fwd (
        .ent_valid  (vld_q),
        .ent_wr_en  (mem_wr_en),
        .ent_mem_rd (mem_mem_rd),
        .ent_wr_reg (wr_reg_q),
        .ent_result (result_q),
        .fwd_valid  (fwd_valid),
        .fwd_reg    (fwd_reg),
        .fwd_data   (fwd_data)
    );

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: scoreboard of accepted entries checked as they drain.
module tb_ex_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid, ex_ready;
    logic [15:0] ex_result, ex_st_data;
    logic        ex_wr_en, ex_mem_rd, ex_mem_wr, ex_halt, ex_flush;
    logic [2:0]  ex_wr_reg;
    logic        mem_valid, mem_ready;
    logic [15:0] mem_result, mem_st_data;
    logic        mem_wr_en, mem_mem_rd, mem_mem_wr;
    logic [2:0]  mem_wr_reg;
    logic        fwd_valid;
    logic [2:0]  fwd_reg;
    logic [15:0] fwd_data;
    logic        halted;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] sd;
        logic        we;
        logic [2:0]  wr;
        logic        rd;
        logic        wm;
    } ent_t;

    localparam logic [1:0] M_RUN = 2'd0, M_DRAIN = 2'd1, M_HALTED = 2'd2;

    ent_t       q[$];
    logic       m_vld;
    logic [1:0] m_state;
    int         total = 0;
    int         bad   = 0;

    ex_mem_stage #(.DW(16), .RW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
        .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg), .ex_mem_rd(ex_mem_rd),
        .ex_mem_wr(ex_mem_wr), .ex_st_data(ex_st_data), .ex_halt(ex_halt),
        .ex_flush(ex_flush), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_result(mem_result), .mem_st_data(mem_st_data), .mem_wr_en(mem_wr_en),
        .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr), .mem_wr_reg(mem_wr_reg),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [15:0] res, input logic we,
                         input logic [2:0] wr, input logic rd, input logic wm,
                         input logic hlt, input logic fl);
        ex_valid   = v;
        ex_result  = res;
        ex_st_data = ~res;
        ex_wr_en   = we;
        ex_wr_reg  = wr;
        ex_mem_rd  = rd;
        ex_mem_wr  = wm;
        ex_halt    = hlt;
        ex_flush   = fl;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One cycle: check outputs against the model, update the scoreboard, advance to next negedge.
    task automatic step(input string tag);
        logic exp_rdy, xfer, drn;
        ent_t e;
        #1;
        exp_rdy = (m_state == M_RUN) && (!m_vld || mem_ready);
        total++; if (ex_ready !== exp_rdy) begin bad++; $display("FAIL %s ex_ready got=%b exp=%b", tag, ex_ready, exp_rdy); end
        total++; if (mem_valid !== m_vld) begin bad++; $display("FAIL %s mem_valid got=%b exp=%b", tag, mem_valid, m_vld); end
        total++; if (halted !== (m_state == M_HALTED)) begin bad++; $display("FAIL %s halted got=%b exp=%b", tag, halted, m_state == M_HALTED); end
        if (m_vld && q.size() > 0) begin
            e = q[0];
            total++; if (mem_result !== e.res) begin bad++; $display("FAIL %s mem_result got=%h exp=%h", tag, mem_result, e.res); end
            total++; if (mem_st_data !== e.sd) begin bad++; $display("FAIL %s mem_st_data got=%h exp=%h", tag, mem_st_data, e.sd); end
            total++; if ({mem_wr_en, mem_wr_reg, mem_mem_rd, mem_mem_wr} !== {e.we, e.wr, e.rd, e.wm}) begin
                bad++; $display("FAIL %s mem_ctrl got=%b exp=%b", tag, {mem_wr_en, mem_wr_reg, mem_mem_rd, mem_mem_wr}, {e.we, e.wr, e.rd, e.wm}); end
            total++; if (fwd_valid !== (e.we && !e.rd)) begin bad++; $display("FAIL %s fwd_valid got=%b exp=%b", tag, fwd_valid, e.we && !e.rd); end
        end else if (m_vld) begin
            total++; bad++; $display("FAIL %s scoreboard empty while entry expected", tag);
        end else begin
            total++; if ({mem_wr_en, mem_mem_rd, mem_mem_wr, fwd_valid} !== 4'b0) begin
                bad++; $display("FAIL %s empty_ctrl got=%b exp=0000", tag, {mem_wr_en, mem_mem_rd, mem_mem_wr, fwd_valid}); end
        end
        drn  = m_vld && mem_ready;
        xfer = ex_valid && exp_rdy && !ex_flush;
        if (drn && q.size() > 0) void'(q.pop_front());
        if (xfer) q.push_back('{ex_result, ex_st_data, ex_wr_en, ex_wr_reg, ex_mem_rd, ex_mem_wr});
        if (m_state == M_RUN && xfer && ex_halt) m_state = M_DRAIN;
        else if (m_state == M_DRAIN && drn) m_state = M_HALTED;
        m_vld = xfer ? 1'b1 : (drn ? 1'b0 : m_vld);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_vld   = 1'b0;
        m_state = M_RUN;
        q.delete();
    endtask

    task automatic do_reset();
        idle();
        mem_ready = 1'b1;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({mem_valid, fwd_valid, halted} !== 3'b000) begin bad++; $display("FAIL reset flags got=%b exp=000", {mem_valid, fwd_valid, halted}); end
        total++; if ({mem_result, mem_st_data, mem_wr_reg} !== 35'd0) begin bad++; $display("FAIL reset data got=%h exp=0", {mem_result, mem_st_data, mem_wr_reg}); end
        total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL reset ex_ready got=%b exp=1", ex_ready); end
    endtask

    task automatic test_stream();
        logic [15:0] vals [3];
        vals[0] = 16'h8001; vals[1] = 16'h4000; vals[2] = 16'hFFFF;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vals[i], 1'b1, 3'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0);
            step("stream");
        end
        idle();
        total++; if (mem_result !== 16'hFFFF) begin bad++; $display("FAIL stream last got=%h exp=ffff", mem_result); end
        step("stream_tail");
        step("stream_idle");
    endtask

    task automatic test_backpressure();
        mem_ready = 1'b1;
        drive(1'b1, 16'h1234, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        step("bp_cap");
        mem_ready = 1'b0;
        drive(1'b1, 16'h5678, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("bp_stall");
        total++; if (mem_result !== 16'h1234) begin bad++; $display("FAIL bp_hold got=%h exp=1234", mem_result); end
        mem_ready = 1'b1;
        step("bp_release");
        idle();
        total++; if (mem_result !== 16'h5678) begin bad++; $display("FAIL bp_next got=%h exp=5678", mem_result); end
        step("bp_drain");
        step("bp_idle");
    endtask

    task automatic test_flush();
        mem_ready = 1'b1;
        drive(1'b1, 16'h0F0F, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        step("fl_cap");
        drive(1'b1, 16'hDEAD, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1);
        step("fl_kill");
        idle();
        total++; if (mem_valid !== 1'b0 || mem_result === 16'hDEAD) begin bad++; $display("FAIL flush got vld=%b res=%h exp vld=0 res!=dead", mem_valid, mem_result); end
        ex_flush = 1'b1;
        step("fl_novalid");
        idle();
        step("fl_idle");
    endtask

    task automatic test_forwarding();
        mem_ready = 1'b0;
        drive(1'b1, 16'h00A5, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step("fw_alu");
        total++; if ({fwd_valid, fwd_reg, fwd_data} !== {1'b1, 3'd5, 16'h00A5}) begin
            bad++; $display("FAIL fwd_alu got=%b/%0d/%h exp=1/5/00a5", fwd_valid, fwd_reg, fwd_data); end
        mem_ready = 1'b1;
        drive(1'b1, 16'h0100, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("fw_load");
        mem_ready = 1'b0;
        idle();
        total++; if (fwd_valid !== 1'b0) begin bad++; $display("FAIL fwd_load got=%b exp=0", fwd_valid); end
        step("fw_load_hold");
        mem_ready = 1'b1;
        drive(1'b1, 16'h7777, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        step("fw_nowr");
        idle();
        total++; if (fwd_valid !== 1'b0) begin bad++; $display("FAIL fwd_nowr got=%b exp=0", fwd_valid); end
        step("fw_drain");
        step("fw_idle");
    endtask

    task automatic test_halt();
        mem_ready = 1'b0;
        drive(1'b1, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("h_accept");
        idle();
        for (int i = 0; i < 2; i++) step("h_stall");
        total++; if ({ex_ready, halted} !== 2'b00) begin bad++; $display("FAIL halt_stall got=%b exp=00", {ex_ready, halted}); end
        mem_ready = 1'b1;
        step("h_drain");
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_set got=%b exp=1", halted); end
        drive(1'b1, 16'hBEEF, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step("h_ignore");
        total++; if ({mem_valid, halted} !== 2'b01) begin bad++; $display("FAIL halt_sticky got=%b exp=01", {mem_valid, halted}); end
        do_reset();
        drive(1'b1, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("h_flushed");
        idle();
        step("h_flushed_idle");
        total++; if ({halted, ex_ready} !== 2'b01) begin bad++; $display("FAIL halt_flushed got=%b exp=01", {halted, ex_ready}); end
    endtask

    task automatic test_async_reset();
        mem_ready = 1'b0;
        drive(1'b1, 16'h3C3C, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        step("ar_cap");
        idle();
        step("ar_stall");
        #3;
        rst_n = 1'b0;
        #1;
        total++; if ({mem_valid, fwd_valid, halted} !== 3'b000) begin
            bad++; $display("FAIL async_reset got=%b exp=000", {mem_valid, fwd_valid, halted}); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        drive(1'b1, 16'hA5A5, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ar_run");
        idle();
        step("ar_drain");
        step("ar_idle");
    endtask

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b1;
        idle();
        model_reset();
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_forwarding();
        test_halt();
        test_async_reset();
        total++; if (q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
